// File: rtl/radius_frame_streamer.sv
// Frame buffer between the radius sampler and plane_surf_calc: fill, gap-free replay, result collection.
// Optional RADIUS_FRAME_TAG_EN adds an 8-bit result tag that advances on every result handshake.
module radius_frame_streamer #(
    parameter int FRAME_LEN = 64,
    parameter int DATA_W    = 16,
    parameter int SURF_W    = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_radius,
    output logic              calc_en,
    output logic [DATA_W-1:0] calc_radius,
    input  logic              calc_rdy,
    input  logic [SURF_W-1:0] calc_surf,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [SURF_W-1:0] m_surf,
    output logic              m_err,
`ifdef RADIUS_FRAME_TAG_EN
    output logic [7:0]        m_tag,
`endif
    output logic              busy
);

    localparam int PTR_W  = $clog2(FRAME_LEN);
    localparam int SCNT_W = $clog2(FRAME_LEN + 2);
    localparam int TMO_W  = $clog2(TIMEOUT);

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [PTR_W-1:0]  LAST_PTR    = PTR_W'(FRAME_LEN - 1);
    localparam logic [SCNT_W-1:0] READ_END    = SCNT_W'(FRAME_LEN);
    localparam logic [SCNT_W-1:0] STREAM_LAST = SCNT_W'(FRAME_LEN + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0]  RDY_GUARD   = TMO_W'(2);

    logic [1:0]        state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [SCNT_W-1:0] stream_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] frame_buf [FRAME_LEN];

    logic accept;
    logic result_taken;

    assign accept       = (state == ST_FILL) && s_valid && s_ready;
    assign result_taken = (state == ST_HOLD) && m_valid && m_ready;
    assign busy         = (state != ST_FILL);

    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf[wr_ptr] <= s_radius;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FILL;
            wr_ptr      <= '0;
            stream_cnt  <= '0;
            tmo_cnt     <= '0;
            rd_vld      <= 1'b0;
            rd_data     <= '0;
            s_ready     <= 1'b1;
            calc_en     <= 1'b0;
            calc_radius <= '0;
            m_valid     <= 1'b0;
            m_surf      <= '0;
            m_err       <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (wr_ptr == LAST_PTR) begin
                            wr_ptr     <= '0;
                            s_ready    <= 1'b0;
                            stream_cnt <= '0;
                            state      <= ST_STREAM;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    // Read stage feeds the output stage; calc_en mirrors rd_vld one cycle later.
                    rd_vld <= (stream_cnt < READ_END);
                    if (stream_cnt < READ_END) begin
                        rd_data <= frame_buf[stream_cnt[PTR_W-1:0]];
                    end
                    calc_en <= rd_vld;
                    if (rd_vld) begin
                        calc_radius <= rd_data;
                    end
                    if (stream_cnt == STREAM_LAST) begin
                        stream_cnt <= '0;
                        tmo_cnt    <= '0;
                        state      <= ST_WAIT;
                    end else begin
                        stream_cnt <= stream_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // The first two cycles may still see the previous frame's rdy level.
                    if ((tmo_cnt >= RDY_GUARD) && calc_rdy) begin
                        m_surf  <= calc_surf;
                        m_err   <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= ST_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        m_surf  <= '0;
                        m_err   <= 1'b1;
                        m_valid <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_taken) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

`ifdef RADIUS_FRAME_TAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tag <= '0;
        end else if (result_taken) begin
            m_tag <= m_tag + 8'd1;
        end
    end
`endif

endmodule
